// File: rtl/si53xx_spi_responder_if.sv
// Serial link plus write/error observation signals of the Si53xx SPI responder.
// The master modport is the SPI controller side; the slave modport is the responder.
interface si53xx_spi_responder_if #(
  parameter int PAGE_BITS = 2
);
  logic                   sclk;
  logic                   ncs;
  logic                   sdi;
  logic                   sdo;
  logic                   sdo_oe;
  logic                   wr_valid;
  logic [PAGE_BITS+7:0]   wr_addr;
  logic [7:0]             wr_data;
  logic                   cmd_error;

  modport master (
    output sclk, ncs, sdi,
    input  sdo, sdo_oe, wr_valid, wr_addr, wr_data, cmd_error
  );

  modport slave (
    input  sclk, ncs, sdi,
    output sdo, sdo_oe, wr_valid, wr_addr, wr_data, cmd_error
  );
endinterface

// File: rtl/si53xx_spi_responder.sv
// Si53xx-style paged-register SPI target, oversampling the SPI pins on clk.
// Byte completion is decoded one cycle after the synchronized sclk rise and committed one cycle later.
module si53xx_spi_responder #(
  parameter int PAGE_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  si53xx_spi_responder_if.slave   bus
);
  localparam int AW = PAGE_BITS + 8;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_IGNORE} state_t;

  function automatic logic cmd_valid(input logic [7:0] c);
    return c inside {8'h00, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hE0};
  endfunction

  function automatic logic cmd_read(input logic [7:0] c);
    return c inside {8'h80, 8'hA0};
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      sclk_sync_q, ncs_sync_q;
  logic [1:0]      sdi_sync_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      shift_q;
  logic [7:0]      cmd_q, rd_sh_q;
  logic [7:0]      ptr_q;
  logic [PAGE_BITS-1:0] page_q;
  logic [AW-1:0]   pend_addr_q;
  logic [7:0]      pend_data_q;
  logic            wr_pend_q, inc_pend_q, load_pend_q, err_pend_q;
  logic            sdo_q, sdo_oe_q, wr_valid_q, cmd_error_q;
  logic [AW-1:0]   wr_addr_q;
  logic [7:0]      wr_data_q;
  logic [7:0]      regs_q [0:(1<<AW)-1];

  logic            sclk_rise, sclk_fall, ncs_high, ncs_fall, byte_done;
  logic [7:0]      byte_w, rd_byte;
  logic            wr_go, inc_go, load_go, err_go, rd_go, cmd_go;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ncs_high  = ncs_sync_q[1];
  // ncs history resets low, so a fall is only seen after ncs has been observed high
  assign ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];
  assign byte_w    = {shift_q, sdi_sync_q[1]};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) &&
                     ((state_q == S_CMD) || (state_q == S_DATA));
  assign rd_byte   = (ptr_q == 8'h01) ? 8'(page_q) : regs_q[{page_q, ptr_q}];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wr_go     = 1'b0;
    inc_go    = 1'b0;
    load_go   = 1'b0;
    err_go    = 1'b0;
    rd_go     = 1'b0;
    cmd_go    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ncs_fall) begin
          state_d   = S_CMD;
          bit_cnt_d = '0;
        end
      end
      S_CMD, S_DATA: begin
        if (sclk_rise) bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: ;
    endcase
    if (byte_done && (state_q == S_CMD)) begin
      cmd_go = 1'b1;
      if (cmd_valid(byte_w)) begin
        state_d = S_DATA;
        rd_go   = cmd_read(byte_w);
      end else begin
        state_d = S_IGNORE;
        err_go  = 1'b1;
      end
    end
    if (byte_done && (state_q == S_DATA)) begin
      unique case (cmd_q)
        8'h00:        load_go = 1'b1;
        8'h40:        wr_go   = 1'b1;
        8'h60, 8'hE0: begin wr_go = 1'b1; inc_go = 1'b1; end
        8'hA0:        inc_go  = 1'b1;
        default: ;
      endcase
      state_d = (cmd_q == 8'hE0) ? S_DATA : S_IGNORE;
    end
    // ncs high wins, but a byte completing in the same cycle has already been decoded above
    if (ncs_high) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end
  end

  // stage p0: synchronizers; stage p1: decode; stage p2: commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;
      sdi_sync_q  <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      wr_pend_q   <= 1'b0;
      inc_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
      ptr_q       <= '0;
      page_q      <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
      ncs_sync_q  <= {ncs_sync_q[1:0], bus.ncs};
      sdi_sync_q  <= {sdi_sync_q[0], bus.sdi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_pend_q   <= wr_go;
      inc_pend_q  <= inc_go;
      load_pend_q <= load_go;
      err_pend_q  <= err_go;
      wr_valid_q  <= wr_pend_q;
      cmd_error_q <= err_pend_q;
      if (wr_pend_q) begin
        wr_addr_q <= pend_addr_q;
        wr_data_q <= pend_data_q;
        if (pend_addr_q[7:0] == 8'h01) page_q <= pend_data_q[PAGE_BITS-1:0];
      end
      if (load_pend_q)     ptr_q <= pend_data_q;
      else if (inc_pend_q) ptr_q <= ptr_q + 8'd1;
      if (ncs_high) begin
        sdo_q    <= 1'b0;
        sdo_oe_q <= 1'b0;
      end else if (sclk_fall && (state_q == S_DATA) && cmd_read(cmd_q)) begin
        sdo_q    <= rd_sh_q[7];
        sdo_oe_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclk_rise) shift_q <= byte_w[6:0];
    if (cmd_go)    cmd_q   <= byte_w;
    if (byte_done) begin
      pend_addr_q <= {page_q, ptr_q};
      pend_data_q <= byte_w;
    end
    if (rd_go)
      rd_sh_q <= rd_byte;
    else if (sclk_fall && (state_q == S_DATA))
      rd_sh_q <= {rd_sh_q[6:0], 1'b0};
    // address 0x01 is the page register and never lands in the array
    if (wr_pend_q && (pend_addr_q[7:0] != 8'h01))
      regs_q[pend_addr_q] <= pend_data_q;
  end

  assign bus.sdo       = sdo_q;
  assign bus.sdo_oe    = sdo_oe_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cmd_error = cmd_error_q;
endmodule
